// File: rtl/calc_engine.sv
// calc_engine: host-loadable instruction/data memories with a two-cycle-per-instruction accumulator sequencer.
// Optional watchdog abort enabled by defining CALC_WDOG_EN (budget MAX_STEPS executed instructions).
module calc_engine #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  input  logic                inst_we,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [4+ADDR_W-1:0] inst_in,
  output logic [4+ADDR_W-1:0] inst_out,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   acc_out,
  output logic [1:0]          flags
);

  localparam int unsigned INST_W = 4 + ADDR_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   dmem [DEPTH];
  logic [INST_W-1:0]   imem [DEPTH];

  logic [ADDR_W-1:0]   pc, pc_n;
  logic [INST_W-1:0]   ir, ir_n;
  logic [DATA_W-1:0]   acc, acc_n;
  logic                carry, carry_n;
  logic                zero, zero_n;
  logic                err, err_n;
  logic                busy_n, done_n;
  logic                acc_upd;

  logic                dm_we;
  logic [ADDR_W-1:0]   dm_waddr;
  logic [DATA_W-1:0]   dm_wdata;
  logic                im_we;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   opnd;
  logic [DATA_W-1:0]   mem_rd;

  assign opcode = ir[INST_W-1 -: 4];
  assign opnd   = ir[ADDR_W-1:0];
  assign mem_rd = dmem[opnd];
  assign im_we  = inst_we && !busy;

`ifdef CALC_WDOG_EN
  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] steps, steps_n;
`else
  logic unused_max_steps;
  assign unused_max_steps = |32'(MAX_STEPS);
`endif

  // Next-state, datapath and memory-write selection
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    acc_n    = acc;
    carry_n  = carry;
    zero_n   = zero;
    err_n    = err;
    acc_upd  = 1'b0;
    dm_we    = data_we && !busy;
    dm_waddr = data_addr;
    dm_wdata = data_in;
`ifdef CALC_WDOG_EN
    steps_n  = steps;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
          acc_n   = '0;
          carry_n = 1'b0;
          zero_n  = 1'b0;
          err_n   = 1'b0;
`ifdef CALC_WDOG_EN
          steps_n = '0;
`endif
        end
      end
      S_FETCH: begin
        ir_n    = imem[pc];
        state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc + ADDR_W'(1);
`ifdef CALC_WDOG_EN
        steps_n = steps + STEP_W'(1);
`endif
        case (opcode)
          OP_NOP: ;
          OP_LD: begin
            acc_n   = mem_rd;
            acc_upd = 1'b1;
          end
          OP_ST: begin
            dm_we    = 1'b1;
            dm_waddr = opnd;
            dm_wdata = acc;
          end
          OP_ADD: begin
            {carry_n, acc_n} = {1'b0, acc} + {1'b0, mem_rd};
            acc_upd = 1'b1;
          end
          OP_SUB: begin
            // Bit DATA_W of the zero-extended difference is the borrow
            {carry_n, acc_n} = {1'b0, acc} - {1'b0, mem_rd};
            acc_upd = 1'b1;
          end
          OP_AND: begin
            acc_n   = acc & mem_rd;
            acc_upd = 1'b1;
          end
          OP_OR: begin
            acc_n   = acc | mem_rd;
            acc_upd = 1'b1;
          end
          OP_XOR: begin
            acc_n   = acc ^ mem_rd;
            acc_upd = 1'b1;
          end
          OP_LDI: begin
            acc_n   = DATA_W'(opnd);
            acc_upd = 1'b1;
          end
          OP_JMP: pc_n = opnd;
          OP_JZ: begin
            if (zero) pc_n = opnd;
          end
          OP_SHL: begin
            carry_n = acc[DATA_W-1];
            acc_n   = {acc[DATA_W-2:0], 1'b0};
            acc_upd = 1'b1;
          end
          OP_SHR: begin
            carry_n = acc[0];
            acc_n   = {1'b0, acc[DATA_W-1:1]};
            acc_upd = 1'b1;
          end
          OP_HALT: state_n = S_DONE;
          default: begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end
        endcase
        if (acc_upd) zero_n = (acc_n == '0);
`ifdef CALC_WDOG_EN
        // Budget exhausted: the current instruction has completed, abort the run
        if (state_n == S_FETCH && steps_n == STEP_W'(MAX_STEPS)) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end
`endif
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_FETCH) || (state_n == S_EXEC);
    done_n = (state_n == S_DONE);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      inst_out <= '0;
`ifdef CALC_WDOG_EN
      steps    <= '0;
`endif
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      acc      <= acc_n;
      carry    <= carry_n;
      zero     <= zero_n;
      err      <= err_n;
      busy     <= busy_n;
      done     <= done_n;
      data_out <= (dm_we && dm_waddr == data_addr) ? dm_wdata : dmem[data_addr];
      inst_out <= (im_we && inst_addr == inst_addr) ? inst_in : imem[inst_addr];
`ifdef CALC_WDOG_EN
      steps    <= steps_n;
`endif
    end
  end

  // Memories are not reset so a reset mid-run keeps loaded program and results
  always_ff @(posedge clk) begin
    if (dm_we) dmem[dm_waddr] <= dm_wdata;
    if (im_we) imem[inst_addr] <= inst_in;
  end

  assign acc_out = acc;
  assign flags   = {carry, zero};
  assign error   = err;

endmodule
